// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and defaults for the CNN feeder blocks
package cnn_pkg;

    localparam int LANE_W         = 8;
    localparam int PEA_NUM_DEF    = 32;
    localparam int CHANNEL_IN_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        BODY,
        DRAIN,
        DONE
    } feeder_state_e;

endpackage

// File: rtl/feeder_fifo2.sv
// rtl/feeder_fifo2.sv - two-entry output FIFO, push side unchecked, valid/ready pop side
module feeder_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    output logic         rd_tvalid_o,
    input  logic         rd_tready_i,
    output logic [W-1:0] rd_tdata_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         pop;

    assign rd_tvalid_o = (count_q != 2'd0);
    assign rd_tdata_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign pop         = rd_tvalid_o && rd_tready_i;

    // The issuer never pushes into a full FIFO, so push/pop need no guards here.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ wr_en_i;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, wr_en_i} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/snake_scan_feeder.sv
// rtl/snake_scan_feeder.sv - streams a feature map from SRAM in serpentine PE order
module snake_scan_feeder
    import cnn_pkg::*;
#(
    parameter int ROW        = 128,
    parameter int COL        = 128,
    parameter int CHANNEL_IN = CHANNEL_IN_DEF,
    parameter int PEA_num    = PEA_NUM_DEF,
    parameter int ADDR_W     = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [CHANNEL_IN*LANE_W-1:0] rd_data,
    output logic [PEA_num*LANE_W-1:0]   data_out,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int RW = $clog2(ROW) + 1;
    localparam int CW = $clog2(COL) + 1;
    localparam int DW = CHANNEL_IN * LANE_W;

    if (ROW < 2) begin : g_row_chk
        $error("snake_scan_feeder: ROW must be >= 2");
    end
    if (PEA_num < CHANNEL_IN) begin : g_lane_chk
        $error("snake_scan_feeder: PEA_num must be >= CHANNEL_IN");
    end

    feeder_state_e     state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              inflight_q;
    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic [DW-1:0]     fifo_data;
    logic              pop;
    logic [1:0]        occ;
    logic              issue;

    feeder_fifo2 #(.W(DW)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (inflight_q),
        .wr_data_i   (rd_data),
        .rd_tvalid_o (fifo_valid),
        .rd_tready_i (data_ready),
        .rd_tdata_o  (fifo_data),
        .count_o     (fifo_count)
    );

    assign pop        = fifo_valid && data_ready;
    assign data_valid = fifo_valid;
    // Credit the beat leaving this cycle so a held-high ready sustains one beat per cycle.
    assign occ        = fifo_count + {1'b0, inflight_q} - {1'b0, pop};
    assign issue      = ((state_q == HEAD) || (state_q == BODY)) && (occ < 2'd2);
    assign rd_en      = issue;
    assign rd_addr    = base_q + ADDR_W'(row_q) * ADDR_W'(COL) + ADDR_W'(col_q);

    always_comb begin
        data_out = '0;
        if (fifo_valid) begin
            data_out[DW-1:0] = fifo_data;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HEAD;
                    row_d   = '0;
                    col_d   = '0;
                    base_d  = base_addr;
                end
            end
            HEAD: begin
                busy = 1'b1;
                if (issue) begin
                    if (row_q == '0) begin
                        row_d = RW'(1);
                    end else if (col_q != CW'(COL - 1)) begin
                        row_d = '0;
                        col_d = col_q + CW'(1);
                    end else if (ROW == 2) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = BODY;
                        row_d   = RW'(2);
                        col_d   = CW'(COL - 1);
                    end
                end
            end
            BODY: begin
                busy = 1'b1;
                if (issue) begin
                    // Odd rows run left to right, even rows right to left.
                    if (row_q[0] ? (col_q == CW'(COL - 1)) : (col_q == '0)) begin
                        if (row_q == RW'(ROW - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + RW'(1);
                            col_d = row_q[0] ? CW'(COL - 1) : '0;
                        end
                    end else begin
                        col_d = row_q[0] ? (col_q + CW'(1)) : (col_q - CW'(1));
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            base_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            base_q     <= base_d;
            inflight_q <= issue;
        end
    end

endmodule

// File: tb/tb_snake_scan_feeder.sv
// tb/tb_snake_scan_feeder.sv - self-checking bench for snake_scan_feeder
module tb_snake_scan_feeder;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_a, rd_en_a, valid_a, ready_a, busy_a, done_a;
    logic [AW-1:0] base_a, rd_addr_a;
    logic [31:0]   rd_data_a;
    logic [255:0]  dout_a;
    logic          start_b, rd_en_b, valid_b, ready_b, busy_b, done_b;
    logic [AW-1:0] base_b, rd_addr_b;
    logic [31:0]   rd_data_b;
    logic [63:0]   dout_b;

    logic [31:0]  mem [DEPTH];
    int           checks = 0;
    int           errors = 0;
    int           model_q[$];
    int           rd_q[$];
    int           exp_q[$];
    logic [31:0]  got_b[$];
    int           beats_a, done_cnt_a, issued_a, accepted_a, occ_a;
    logic         pv, pr;
    logic [255:0] pd, exp_beat;

    snake_scan_feeder #(.ROW(4), .COL(4), .CHANNEL_IN(4), .PEA_num(32), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .data_out(dout_a), .data_valid(valid_a), .data_ready(ready_a),
        .busy(busy_a), .done(done_a)
    );

    snake_scan_feeder #(.ROW(3), .COL(2), .CHANNEL_IN(4), .PEA_num(8), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .data_out(dout_b), .data_valid(valid_b), .data_ready(ready_b),
        .busy(busy_b), .done(done_b)
    );

    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serpentine visiting order: rows 0/1 interleaved per column, then alternating row direction.
    function automatic void gen_order(input int rows, input int cols, input int base);
        model_q.delete();
        for (int c = 0; c < cols; c++) begin
            model_q.push_back((base + c) % DEPTH);
            model_q.push_back((base + cols + c) % DEPTH);
        end
        for (int r = 2; r < rows; r++) begin
            for (int k = 0; k < cols; k++) begin
                int c;
                c = (r % 2 == 0) ? (cols - 1 - k) : k;
                model_q.push_back((base + r * cols + c) % DEPTH);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0; pr = 1'b0; issued_a = 0; accepted_a = 0;
        end else begin
            if (rd_en_a) begin
                occ_a = issued_a - accepted_a + 1 - ((valid_a && ready_a) ? 1 : 0);
                chk("occupancy_le_2", 256'(occ_a <= 2), 256'(1));
                chk("read_expected", 256'(rd_q.size() > 0), 256'(1));
                if (rd_q.size() > 0) chk("rd_addr", 256'(rd_addr_a), 256'(rd_q.pop_front()));
                issued_a++;
            end
            if (valid_a && ready_a) begin
                chk("beat_expected", 256'(exp_q.size() > 0), 256'(1));
                if (exp_q.size() > 0) begin
                    exp_beat = {224'b0, mem[AW'(exp_q.pop_front())]};
                    chk("beat_data", dout_a, exp_beat);
                end
                chk("upper_lanes_zero", 256'(dout_a[255:32]), 256'(0));
                beats_a++;
                accepted_a++;
            end
            if (pv && !pr) begin
                chk("stall_valid", 256'(valid_a), 256'(1));
                chk("stall_data", dout_a, pd);
            end
            if (done_a) done_cnt_a++;
            pv = valid_a; pr = ready_a; pd = dout_a;
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid_b && ready_b) begin
            got_b.push_back(dout_b[31:0]);
            chk("b_upper_lanes_zero", 256'(dout_b[63:32]), 256'(0));
        end
    end

    task automatic frame_a(input int base, input int mode, input bit repulse);
        int cyc;
        logic [AW-1:0] b;
        b = AW'(base);
        gen_order(4, 4, base);
        rd_q = model_q; exp_q = model_q;
        beats_a = 0; done_cnt_a = 0;
        ready_a = 1'b1; start_a = 1'b1; base_a = b;
        @(posedge clk); #1;
        start_a = 1'b0; base_a = AW'($urandom);
        chk("busy_after_start", 256'(busy_a), 256'(1));
        chk("valid_lat0", 256'(valid_a), 256'(0));
        @(posedge clk); #1;
        chk("valid_lat1", 256'(valid_a), 256'(0));
        @(posedge clk); #1;
        chk("valid_lat2", 256'(valid_a), 256'(1));
        cyc = 0;
        while (done_cnt_a == 0 && cyc < 400) begin
            case (mode)
                0:       ready_a = 1'b1;
                1:       ready_a = (cyc >= 6 && cyc < 11) ? 1'b0 : ~cyc[0];
                default: ready_a = ($urandom_range(0, 3) != 0);
            endcase
            if (repulse) begin
                start_a = (cyc == 0) || (cyc >= 12);
                base_a  = AW'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        chk("frame_in_budget", 256'(cyc < 400), 256'(1));
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("done_once", 256'(done_cnt_a), 256'(1));
        chk("beat_count", 256'(beats_a), 256'(16));
        chk("reads_left", 256'(rd_q.size()), 256'(0));
        chk("beats_left", 256'(exp_q.size()), 256'(0));
        chk("busy_after_done", 256'(busy_a), 256'(0));
        chk("valid_after_done", 256'(valid_a), 256'(0));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start_a = 1'b0; base_a = '0; ready_a = 1'b1;
        start_b = 1'b0; base_b = '0; ready_b = 1'b1;
        for (int k = 0; k < DEPTH; k++) mem[k] = {4{k[7:0]}};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", 256'(rd_en_a), 256'(0));
        chk("rst_rd_addr", 256'(rd_addr_a), 256'(0));
        chk("rst_data_out", dout_a, 256'(0));
        chk("rst_valid", 256'(valid_a), 256'(0));
        chk("rst_busy", 256'(busy_a), 256'(0));
        chk("rst_done", 256'(done_a), 256'(0));
        chk("rst_b_addr", 256'(rd_addr_b), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        frame_a(0, 0, 1'b0);
        frame_a(0, 1, 1'b0);
        frame_a(0, 0, 1'b1);
        frame_a(0, 0, 1'b0);

        gen_order(4, 4, 0);
        rd_q = model_q; exp_q = model_q;
        beats_a = 0;
        start_a = 1'b1; base_a = '0;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (beats_a < 9 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_in_budget", 256'(n < 100), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", 256'(rd_en_a), 256'(0));
        chk("midrst_rd_addr", 256'(rd_addr_a), 256'(0));
        chk("midrst_data_out", dout_a, 256'(0));
        chk("midrst_valid", 256'(valid_a), 256'(0));
        chk("midrst_busy", 256'(busy_a), 256'(0));
        rd_q.delete(); exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame_a(0, 0, 1'b0);

        for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
        frame_a(DEPTH - 5, 2, 1'b0);
        for (int i = 0; i < 4; i++) frame_a($urandom_range(0, DEPTH - 1), 2, i[0]);

        gen_order(3, 2, 100);
        got_b.delete();
        start_b = 1'b1; base_b = AW'(100);
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 200) begin
            ready_b = ($urandom_range(0, 1) != 0);
            @(posedge clk); #1;
            n++;
        end
        chk("b_in_budget", 256'(n < 200), 256'(1));
        ready_b = 1'b1;
        @(posedge clk); #1;
        chk("b_busy_after_done", 256'(busy_b), 256'(0));
        chk("b_beat_count", 256'(got_b.size()), 256'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < got_b.size()) chk("b_beat_data", 256'(got_b[i]), 256'(mem[AW'(model_q[i])]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
